stopwatch_counter: RTL and testbench

- Time-base stage that sits directly upstream of the 7-segment display block.
- Keeps elapsed time as total seconds in 0..MAX_COUNT and drives it on number_to_disp, which the display splits into MM:SS.
- Handles run/pause toggling and field adjustment. adj and sel carry the same meaning the display uses for blinking.
- Single-clock design; 1 Hz and 2 Hz rates arrive as one-cycle enable pulses from the clock divider.

---
 rtl/stopwatch_counter.sv | 171 +++++++++++++++++
 tb/tb_stopwatch_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: seconds time base for the MM:SS display.
// Holds elapsed time as total seconds (0..MAX_COUNT). It runs, pauses and
// adjusts the minutes/seconds fields, and drives the value to the display.
// Optional lap-hold feature: define STOPWATCH_LAP_EN to compile it in.
module stopwatch_counter #(
   parameter int WIDTH     = 12,
   parameter int MAX_COUNT = 3599
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_1hz,
   input  logic             tick_2hz,
   input  logic             pause_btn,
   input  logic             adj,
   input  logic             sel,
   input  logic             lap_btn,
   output logic [WIDTH-1:0] number_to_disp,
   output logic             running,
   output logic             lap_active
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_ADJUST = 2'd2
   } state_t;

   localparam int               NUM_MIN = (MAX_COUNT + 1) / 60;
   localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_COUNT);
   localparam logic [WIDTH-1:0] MIN_TH  = WIDTH'(MAX_COUNT - 59);
   localparam logic [WIDTH-1:0] ONE_C   = WIDTH'(1);
   localparam logic [WIDTH-1:0] C59     = WIDTH'(59);
   localparam logic [WIDTH-1:0] C60     = WIDTH'(60);

   state_t           state_q, state_d;
   state_t           saved_q, saved_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] disp_q, disp_d;
   logic             running_q;
   logic             lap_active_q, lap_active_d;
   logic             pause_q, lap_q;
   logic             pause_pulse_s, lap_pulse_s;
   logic             sec59_s;

   assign pause_pulse_s  = pause_btn & ~pause_q;
   assign lap_pulse_s    = lap_btn & ~lap_q;
   assign number_to_disp = disp_q;
   assign running        = running_q;
   assign lap_active     = lap_active_q;

   // Seconds field equals 59: compare against every xx:59 value.
   always_comb begin
      sec59_s = 1'b0;
      for (int i = 0; i < NUM_MIN; i++) begin
         sec59_s = sec59_s | (count_q == WIDTH'(60 * i + 59));
      end
   end

   // Mode FSM: adj has priority over a pause edge; pause is ignored while adjusting.
   always_comb begin
      state_d = state_q;
      saved_d = saved_q;
      case (state_q)
         ST_RUN, ST_PAUSED: begin
            if (adj) begin
               state_d = ST_ADJUST;
               saved_d = state_q;
            end else if (pause_pulse_s) begin
               state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
            end else begin
               state_d = state_q;
            end
         end
         ST_ADJUST: begin
            if (!adj) begin
               state_d = saved_q;
            end else begin
               state_d = ST_ADJUST;
            end
         end
         default: begin
            state_d = ST_RUN;
            saved_d = ST_RUN;
         end
      endcase
   end

   // Count update: 1 Hz advance in RUN (a pause edge drops the tick), field edits on 2 Hz in ADJUST.
   always_comb begin
      count_d = count_q;
      case (state_q)
         ST_RUN: begin
            if (tick_1hz && !pause_pulse_s) begin
               count_d = (count_q == MAX_C) ? '0 : count_q + ONE_C;
            end else begin
               count_d = count_q;
            end
         end
         ST_ADJUST: begin
            if (tick_2hz) begin
               if (sel) begin
                  count_d = sec59_s ? count_q - C59 : count_q + ONE_C;
               end else begin
                  count_d = (count_q >= MIN_TH) ? count_q - MIN_TH : count_q + C60;
               end
            end else begin
               count_d = count_q;
            end
         end
         default: count_d = count_q;
      endcase
   end

`ifdef STOPWATCH_LAP_EN
   // Lap hold: a lap edge toggles the hold outside ADJUST; entering ADJUST clears it.
   always_comb begin
      lap_active_d = lap_active_q;
      if (state_q != ST_ADJUST) begin
         if (adj) begin
            lap_active_d = 1'b0;
         end else if (lap_pulse_s) begin
            lap_active_d = ~lap_active_q;
         end else begin
            lap_active_d = lap_active_q;
         end
      end else begin
         lap_active_d = 1'b0;
      end
   end

   // Display follows count except while the hold stays engaged.
   always_comb begin
      disp_d = count_q;
      if (lap_active_q && lap_active_d) begin
         disp_d = disp_q;
      end else begin
         disp_d = count_q;
      end
   end
`else
   // Without lap hold the lap edge is tracked but never changes the outputs.
   always_comb begin
      lap_active_d = 1'b0 & lap_pulse_s;
      disp_d       = count_q;
   end
`endif

   // State, count and registered outputs; reset overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         saved_q      <= ST_RUN;
         count_q      <= '0;
         disp_q       <= '0;
         running_q    <= 1'b1;
         lap_active_q <= 1'b0;
         pause_q      <= 1'b1;
         lap_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         saved_q      <= saved_d;
         count_q      <= count_d;
         disp_q       <= disp_d;
         running_q    <= (state_d == ST_RUN);
         lap_active_q <= lap_active_d;
         pause_q      <= pause_btn;
         lap_q        <= lap_btn;
      end
   end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: time is modelled as separate minute/second
// fields with a mode variable. A negedge process compares every cycle.
module tb_stopwatch_counter;

   localparam int WIDTH = 12;
   localparam int MAX_COUNT = 3599;
   localparam int M_RUN = 0, M_PAUSED = 1, M_ADJ = 2;

   logic clk = 1'b0;
   logic rst = 1'b1, tick_1hz = 1'b0, tick_2hz = 1'b0, pause_btn = 1'b0;
   logic adj = 1'b0, sel = 1'b0, lap_btn = 1'b0;
   logic [WIDTH-1:0] number_to_disp;
   logic running, lap_active;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   // model state
   int mm, ss, mode, saved, shown, lap;
   bit prev_pb, prev_lb;

   stopwatch_counter #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
      .pause_btn(pause_btn), .adj(adj), .sel(sel), .lap_btn(lap_btn),
      .number_to_disp(number_to_disp), .running(running), .lap_active(lap_active)
   );

   always #5 clk = ~clk;

   // Reference step, applied with the inputs sampled at the clock edge.
   task automatic model_step();
      bit pp, lp;
      int old_total, new_lap;
      if (rst) begin
         mm = 0; ss = 0; mode = M_RUN; saved = M_RUN; shown = 0; lap = 0;
         prev_pb = 1'b1; prev_lb = 1'b1;
         return;
      end
      pp = pause_btn && !prev_pb;
      lp = lap_btn && !prev_lb;
      old_total = mm * 60 + ss;
      if (mode == M_RUN && tick_1hz && !pp) begin
         ss++;
         if (ss == 60) begin ss = 0; mm++; end
         if (mm == 60) mm = 0;
      end else if (mode == M_ADJ && tick_2hz) begin
         if (sel) ss = (ss + 1) % 60;
         else     mm = (mm + 1) % 60;
      end
      new_lap = lap;
`ifdef STOPWATCH_LAP_EN
      if (mode != M_ADJ) begin
         if (adj) new_lap = 0;
         else if (lp) new_lap = 1 - lap;
      end
`endif
      if (!(lap == 1 && new_lap == 1)) shown = old_total;
      lap = new_lap;
      if (mode != M_ADJ) begin
         if (adj) begin saved = mode; mode = M_ADJ; end
         else if (pp) mode = (mode == M_RUN) ? M_PAUSED : M_RUN;
      end else if (!adj) begin
         mode = saved;
      end
      prev_pb = pause_btn;
      prev_lb = lap_btn;
   endtask

   // One clock cycle with the given inputs.
   task automatic cyc(input logic r, input logic t1, input logic t2, input logic pb,
                      input logic ad, input logic se, input logic lb);
      rst = r; tick_1hz = t1; tick_2hz = t2; pause_btn = pb; adj = ad; sel = se; lap_btn = lb;
      @(posedge clk);
      model_step();
      chk_en = 1'b1;
      #1;
   endtask

   task automatic lit(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (number_to_disp != WIDTH'(shown) || running != (mode == M_RUN) ||
             lap_active != (lap == 1)) begin
            bad++;
            $display("FAIL cycle t=%0t: disp=%0d run=%0b lap=%0b expected disp=%0d run=%0b lap=%0b",
                     $time, number_to_disp, running, lap_active, shown, (mode == M_RUN), (lap == 1));
         end
      end
   end

   initial begin
      // reset release, 5 seconds
      cyc(1, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
      lit("reset_disp", int'(number_to_disp), 0);
      lit("reset_run", int'(running), 1);
      lit("reset_lap", int'(lap_active), 0);
      repeat (5) cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      lit("five_ticks", int'(number_to_disp), 5);
      lit("five_run", int'(running), 1);

      // preload 59:59 through adjust, then wrap
      cyc(0, 0, 0, 0, 1, 0, 0);
      repeat (59) cyc(0, 0, 1, 0, 1, 0, 0);
      repeat (54) cyc(0, 0, 1, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      lit("preload_3599", int'(number_to_disp), 3599);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      lit("wrap_zero", int'(number_to_disp), 0);

      // pause edge coinciding with a tick
      repeat (10) cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 0, 0);
      repeat (3) cyc(0, 1, 0, 1, 0, 0, 0);
      lit("paused_hold", int'(number_to_disp), 10);
      lit("paused_run", int'(running), 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      repeat (2) cyc(0, 1, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      lit("resume_12", int'(number_to_disp), 12);

      // field adjust: 12 -> 01:59 -> 01:00 -> 02:00 ... 59:30 -> 00:30
      cyc(0, 0, 0, 0, 1, 0, 0);
      cyc(0, 0, 1, 0, 1, 0, 0);
      repeat (47) cyc(0, 0, 1, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 1, 1, 0);
      lit("adj_119", int'(number_to_disp), 119);
      cyc(0, 0, 1, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      lit("sec_wrap_60", int'(number_to_disp), 60);
      cyc(0, 0, 1, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      lit("min_up_120", int'(number_to_disp), 120);
      repeat (57) cyc(0, 0, 1, 0, 1, 0, 0);
      repeat (30) cyc(0, 0, 1, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 1, 0, 0);
      lit("adj_3570", int'(number_to_disp), 3570);
      cyc(0, 0, 1, 0, 1, 0, 0);
      repeat (3) cyc(0, 1, 0, 0, 1, 0, 0);
      lit("min_wrap_30", int'(number_to_disp), 30);
      lit("adjust_run", int'(running), 0);

      // reset in ADJUST with pause held, then held past reset
      cyc(1, 0, 0, 1, 1, 0, 0);
      lit("rst_run", int'(running), 1);
      cyc(0, 0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0, 0);
      lit("held_pause_run", int'(running), 1);
      lit("held_pause_disp", int'(number_to_disp), 1);
      cyc(0, 0, 0, 0, 0, 0, 0);

`ifdef STOPWATCH_LAP_EN
      // lap hold: freeze at 20, resume at 24, cleared by adjust
      repeat (19) cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      repeat (4) cyc(0, 1, 0, 0, 0, 0, 1);
      lit("lap_freeze", int'(number_to_disp), 20);
      lit("lap_on", int'(lap_active), 1);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      lit("lap_resume", int'(number_to_disp), 24);
      lit("lap_off", int'(lap_active), 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1, 0, 1);
      lit("lap_adj_clear", int'(lap_active), 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
`endif

      // randomized traffic
      begin
         logic pb, ad, se, lb;
         pb = 1'b0; ad = 1'b0; se = 1'b0; lb = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) pb = ~pb;
            if ($urandom_range(0, 40) == 0) ad = ~ad;
            if ($urandom_range(0, 7) == 0) se = ~se;
            if ($urandom_range(0, 5) == 0) lb = ~lb;
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 2) == 0), pb, ad, se, lb);
         end
      end

      chk_en = 1'b0;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
